// File: rtl/des_key_schedule_if.sv
// Key-schedule handshake bundle: key load side plus the round-word stream toward PC2.
// decrypt exists only when DES_KEY_DECRYPT_EN is defined.
interface des_key_schedule_if;
  logic [1:64] key_in;
  logic        key_load;
`ifdef DES_KEY_DECRYPT_EN
  logic        decrypt;
`endif
  logic [1:56] cd_out;
  logic        round_valid;
  logic        round_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  modport master (
`ifdef DES_KEY_DECRYPT_EN
    output decrypt,
`endif
    output key_in, key_load, round_ready,
    input  cd_out, round_valid, round_idx, busy, done
  );

  modport slave (
`ifdef DES_KEY_DECRYPT_EN
    input  decrypt,
`endif
    input  key_in, key_load, round_ready,
    output cd_out, round_valid, round_idx, busy, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule up to PC2: PC-1, then 16 rotated C||D words (decrypt order under DES_KEY_DECRYPT_EN).
// Latency: first word 1 cycle after key_load; 1 word/cycle while round_ready stays high.
// Backpressure: round_ready low freezes cd_out/round_idx with round_valid held; key_load ignored while busy.
module des_key_schedule (
  input logic            clk,
  input logic            rst_n,
  des_key_schedule_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [1:28] c_q, d_q;
  logic [3:0]  idx_q;
  logic        valid_q, busy_q, done_q, dec_q;
  logic        dec_load, step_two, hs;
  logic [1:64] k;
  logic [1:28] c0, d0;
  logic        unused_parity;

  assign k  = bus.key_in;
  assign c0 = {k[57], k[49], k[41], k[33], k[25], k[17], k[9],  k[1],
               k[58], k[50], k[42], k[34], k[26], k[18], k[10], k[2],
               k[59], k[51], k[43], k[35], k[27], k[19], k[11], k[3],
               k[60], k[52], k[44], k[36]};
  assign d0 = {k[63], k[55], k[47], k[39], k[31], k[23], k[15], k[7],
               k[62], k[54], k[46], k[38], k[30], k[22], k[14], k[6],
               k[61], k[53], k[45], k[37], k[29], k[21], k[13], k[5],
               k[28], k[20], k[12], k[4]};
  assign unused_parity = ^{k[8], k[16], k[24], k[32], k[40], k[48], k[56], k[64]};

`ifdef DES_KEY_DECRYPT_EN
  assign dec_load = bus.decrypt;
`else
  assign dec_load = 1'b0;
`endif

  // LS[r] is 1 for rounds 1, 2, 9, 16 and 2 otherwise.
  function automatic logic two_step(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [1:28] rot(input logic [1:28] x, input logic right, input logic two);
    logic [1:28] y;
    case ({right, two})
      2'b00:   y = {x[2:28], x[1]};
      2'b01:   y = {x[3:28], x[1:2]};
      2'b10:   y = {x[28], x[1:27]};
      default: y = {x[27:28], x[1:26]};
    endcase
    return y;
  endfunction

  // Encrypt steps into round idx+2; decrypt undoes round 16-idx.
  assign step_two = dec_q ? two_step(5'd16 - {1'b0, idx_q}) : two_step({1'b0, idx_q} + 5'd2);
  assign hs       = valid_q & bus.round_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.key_load) begin
            c_q     <= dec_load ? c0 : rot(c0, 1'b0, 1'b0);
            d_q     <= dec_load ? d0 : rot(d0, 1'b0, 1'b0);
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            dec_q   <= dec_load;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            if (idx_q == 4'd15) begin
              idx_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              c_q   <= rot(c_q, dec_q, step_two);
              d_q   <= rot(d_q, dec_q, step_two);
              idx_q <= idx_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.cd_out      = {c_q, d_q};
  assign bus.round_valid = valid_q;
  assign bus.round_idx   = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule
